// File: rtl/pkt_len_prepend_if.sv
// pkt_len_prepend_if: byte stream with sop/eop framing and a valid strobe
interface pkt_len_prepend_if;
    logic [7:0] data;
    logic       vld;
    logic       sop;
    logic       eop;
    modport master (output data, vld, sop, eop);
    modport slave (input data, vld, sop, eop);
endinterface

// File: rtl/pkt_len_prepend.sv
// pkt_len_prepend: buffers sop/eop byte packets and re-emits valid ones behind a 2-byte big-endian length
module pkt_len_prepend #(
    parameter int BUF_AW = 11,
    parameter int LEN_AW = 2,
    parameter int MIN_LEN = 46,
    parameter int MAX_LEN = 1500
) (
    input  logic              clk,
    input  logic              rst,
    pkt_len_prepend_if.slave  rx,
    pkt_len_prepend_if.master tx,
    output logic              drop,
    output logic              err_len
);
    localparam int PW = BUF_AW + 1;
    localparam logic [BUF_AW-1:0] MIN_L = BUF_AW'(MIN_LEN);
    localparam logic [BUF_AW-1:0] MAX_L = BUF_AW'(MAX_LEN);
    localparam logic [PW-1:0] DEPTH = PW'(2 ** BUF_AW);
    localparam logic [PW-1:0] MAX_P = PW'(MAX_LEN);

    typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_HDR_H, R_HDR_L, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [7:0] mem [2**BUF_AW];
    logic [7:0] ram_q;
    logic [BUF_AW-1:0] lf [2**LEN_AW];
    logic [LEN_AW:0] lf_wp, lf_rp;
    logic [PW-1:0] wr_ptr, wr_ptr_n, wr_commit, wr_commit_n, rd_ptr, rd_ptr_n;
    logic [BUF_AW-1:0] cnt, cnt_n, len, len_n, waddr, raddr;
    logic we, push, pop, err_n, drop_n, lf_empty, lf_full, space_ok;
    logic [7:0] dout_n;
    logic vld_n, sop_n, eop_n;

    assign lf_empty = lf_wp == lf_rp;
    assign lf_full = (lf_wp ^ lf_rp) == {1'b1, {LEN_AW{1'b0}}};
    assign space_ok = (DEPTH - (wr_commit - rd_ptr)) >= MAX_P && !lf_full;
    // RAM output is registered again into dout, so data reads run one byte ahead of rd_ptr
    assign raddr = rd_ptr[BUF_AW-1:0] + BUF_AW'(r_state == R_DATA);

    always_comb begin
        w_next = w_state;
        wr_ptr_n = wr_ptr;
        wr_commit_n = wr_commit;
        cnt_n = cnt;
        waddr = wr_ptr[BUF_AW-1:0];
        we = 1'b0;
        push = 1'b0;
        err_n = 1'b0;
        drop_n = 1'b0;
        if (rx.vld && w_state == W_DROP) begin
            w_next = rx.eop ? W_IDLE : W_DROP;
            drop_n = rx.eop;
        end else if (rx.vld && rx.sop) begin
            err_n = w_state == W_PKT;
            we = space_ok;
            waddr = wr_commit[BUF_AW-1:0];
            wr_ptr_n = space_ok ? wr_commit + PW'(1) : wr_commit;
            cnt_n = space_ok ? BUF_AW'(1) : cnt;
            w_next = space_ok ? W_PKT : (rx.eop ? W_IDLE : W_DROP);
            drop_n = !space_ok && rx.eop;
        end else if (rx.vld && w_state == W_PKT) begin
            we = cnt < MAX_L;
            wr_ptr_n = wr_ptr + PW'(cnt < MAX_L);
            cnt_n = cnt + BUF_AW'(cnt != '1);
        end
        if (rx.vld && rx.eop && w_next == W_PKT) begin
            w_next = W_IDLE;
            push = cnt_n >= MIN_L && cnt_n <= MAX_L;
            err_n = err_n || !push;
            wr_commit_n = push ? wr_ptr_n : wr_commit;
            wr_ptr_n = push ? wr_ptr_n : wr_commit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            wr_ptr <= '0;
            wr_commit <= '0;
            cnt <= '0;
            lf_wp <= '0;
            drop <= 1'b0;
            err_len <= 1'b0;
        end else begin
            w_state <= w_next;
            wr_ptr <= wr_ptr_n;
            wr_commit <= wr_commit_n;
            cnt <= cnt_n;
            lf_wp <= lf_wp + (LEN_AW+1)'(push);
            drop <= drop_n;
            err_len <= err_n;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= rx.data;
        if (push) lf[lf_wp[LEN_AW-1:0]] <= cnt_n;
        ram_q <= mem[raddr];
    end

    always_comb begin
        r_next = r_state;
        len_n = len;
        rd_ptr_n = rd_ptr;
        pop = 1'b0;
        dout_n = '0;
        vld_n = 1'b0;
        sop_n = 1'b0;
        eop_n = 1'b0;
        case (r_state)
            R_IDLE: begin
                pop = !lf_empty;
                len_n = lf_empty ? len : lf[lf_rp[LEN_AW-1:0]];
                r_next = lf_empty ? R_IDLE : R_HDR_H;
            end
            R_HDR_H: begin
                dout_n = 8'(len >> 8);
                vld_n = 1'b1;
                sop_n = 1'b1;
                r_next = R_HDR_L;
            end
            R_HDR_L: begin
                dout_n = len[7:0];
                vld_n = 1'b1;
                r_next = R_DATA;
            end
            default: begin
                dout_n = ram_q;
                vld_n = 1'b1;
                eop_n = len == BUF_AW'(1);
                len_n = len - BUF_AW'(1);
                rd_ptr_n = rd_ptr + PW'(1);
                r_next = eop_n ? R_IDLE : R_DATA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            len <= '0;
            rd_ptr <= '0;
            lf_rp <= '0;
            tx.data <= '0;
            tx.vld <= 1'b0;
            tx.sop <= 1'b0;
            tx.eop <= 1'b0;
        end else begin
            r_state <= r_next;
            len <= len_n;
            rd_ptr <= rd_ptr_n;
            lf_rp <= lf_rp + (LEN_AW+1)'(pop);
            tx.data <= dout_n;
            tx.vld <= vld_n;
            tx.sop <= sop_n;
            tx.eop <= eop_n;
        end
    end
endmodule
